// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data memory access controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int         TIMEOUT_CNT_W = 8;
    localparam logic [1:0] ALIGN_MASK    = 2'b11;

endpackage

// File: rtl/access_timeout_counter.sv
// Counts REQ cycles without ack; terminal fires on the enabled cycle whose
// edge would bring the count up to TIMEOUT_CYCLES.
module access_timeout_counter
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [TIMEOUT_CNT_W-1:0] LAST_COUNT = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_CNT_W-1:0] count;

    // Signalling one cycle early lets the FSM drop mem_req after exactly
    // TIMEOUT_CYCLES request cycles, since mem_req is registered.
    assign terminal = enable && (count == LAST_COUNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_controller.sv
// MEM-stage sequencer: turns EX/MEM load/store requests into req/ack memory
// transactions, stalls the upstream pipeline, and flags bad accesses.
module mem_access_controller
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  bus_error
);

    // Memory handshake: mem_req rises with mem_addr/mem_we/mem_wdata and all
    // four stay constant until the cycle after mem_ack (a one-cycle pulse) is
    // seen or the timeout aborts; mem_rdata is only sampled with mem_ack.

    state_t state;
    logic   any_access;
    logic   misaligned;
    logic   access_fault;
    logic   valid_req;
    logic   timeout;

    assign any_access   = mem_read || mem_write;
    assign misaligned   = (alu_result[1:0] & ALIGN_MASK) != 2'b00;
    assign access_fault = any_access && ((mem_read && mem_write) || misaligned);
    assign valid_req    = any_access && !access_fault;

    // Nothing stalls while reset is held, even if EX/MEM still shows a request.
    assign stall = !reset && (((state == S_IDLE) && valid_req) || (state == S_REQ));

    access_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == S_IDLE),
        .enable  ((state == S_REQ) && !mem_ack),
        .terminal(timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            read_data <= '0;
            bus_error <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (access_fault) begin
                        bus_error <= 1'b1;
                    end else if (valid_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= mem_write;
                        mem_addr  <= alu_result;
                        mem_wdata <= write_data;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) read_data <= mem_rdata;
                        state   <= S_DONE;
                    end else if (timeout) begin
                        mem_req   <= 1'b0;
                        bus_error <= 1'b1;
                        if (!mem_we) read_data <= '0;
                        state     <= S_DONE;
                    end
                end
                // EX/MEM still holds the finished instruction here; ignore it.
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench: a pipeline/memory driver plus a transaction-level
// reference model predicting stall, request, error and load-data outcomes.
module tb_mem_access_controller;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] alu_result = '0;
    logic [DW-1:0] write_data = '0;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall, mem_req, mem_we, bus_error;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, read_data;

    int checks = 0;
    int errors = 0;

    int            obs_stall, obs_req, obs_err;
    logic          obs_we, obs_unstable;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_wdata, obs_rd;

    int            exp_stall, exp_req, exp_err;
    logic          exp_valid;
    logic [DW-1:0] model_rd = '0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_rd;

    mem_access_controller #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .alu_result(alu_result), .write_data(write_data), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .read_data(read_data),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Transaction-level outcome of one EX/MEM instruction.
    task automatic predict(input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] rdata, input int lat);
        logic is_access, fault, acked;
        is_access = rd || wr;
        fault     = is_access && ((rd && wr) || addr[1:0] != 2'b00);
        acked     = (lat >= 1) && (lat <= TO);
        exp_stall = 0;
        exp_req   = 0;
        exp_err   = 0;
        exp_valid = is_access && !fault;
        if (fault) begin
            exp_err = 1;
        end else if (is_access) begin
            exp_req   = acked ? lat : TO;
            exp_stall = exp_req + 1;
            exp_err   = acked ? 0 : 1;
            if (rd) model_rd = acked ? rdata : '0;
        end
        exp_q.push_back(model_rd);
    endtask

    // Presents one instruction until the pipeline advances, answers the memory
    // after lat request cycles (0 = never), then watches tail idle cycles.
    task automatic run_access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                              input int lat, input int tail);
        bit advanced = 0;
        bit finished = 0;
        int post = 0;
        mem_read = rd; mem_write = wr; alu_result = addr; write_data = wdata;
        obs_stall = 0; obs_req = 0; obs_err = 0; obs_unstable = 0; obs_rd = '0;
        obs_we = 1'b0; obs_addr = '0; obs_wdata = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (mem_req) begin
                obs_req++;
                if (obs_req == 1) begin
                    obs_we = mem_we; obs_addr = mem_addr; obs_wdata = mem_wdata;
                end else if (mem_we !== obs_we || mem_addr !== obs_addr || mem_wdata !== obs_wdata) begin
                    obs_unstable = 1'b1;
                end
                if (obs_req == lat) begin
                    mem_ack = 1'b1; mem_rdata = rdata;
                end
            end
            if (stall) obs_stall++;
            if (bus_error) obs_err++;
            if (advanced) post++;
            else if (!stall) begin
                advanced = 1; obs_rd = read_data;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (advanced) begin
                if (post == 0) begin
                    mem_read = 1'b0; mem_write = 1'b0; alu_result = '0; write_data = '0;
                end
                if (post >= tail) begin
                    finished = 1;
                    break;
                end
            end
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL access_bound: addr=%h never released the pipeline within 400 cycles", addr);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({stall, mem_req, mem_we, bus_error} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got stall/req/we/err=%b want 0000", {stall, mem_req, mem_we, bus_error});
        end
        checks++;
        if ({mem_addr, mem_wdata, read_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want all 0", mem_addr, mem_wdata, read_data);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_zero_wait;
        predict(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 1);
        run_access(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1, 3);
        exp_rd = exp_q.pop_front();
        checks++;
        if (obs_stall != exp_stall) begin errors++; $display("FAIL load0_stall: got %0d want %0d", obs_stall, exp_stall); end
        checks++;
        if (obs_req != exp_req) begin errors++; $display("FAIL load0_req: got %0d want %0d", obs_req, exp_req); end
        checks++;
        if (obs_rd !== exp_rd) begin errors++; $display("FAIL load0_rdata: got %h want %h", obs_rd, exp_rd); end
        checks++;
        if (obs_addr !== 32'h10 || obs_we !== 1'b0 || obs_err != exp_err) begin
            errors++; $display("FAIL load0_bus: got addr=%h we=%b err=%0d want 10/0/%0d", obs_addr, obs_we, obs_err, exp_err);
        end
    endtask

    task automatic test_store_wait;
        predict(1'b0, 1'b1, 32'h20, 32'hFFFF_0000, 3);
        run_access(1'b0, 1'b1, 32'h20, 32'h1234_5678, 32'hFFFF_0000, 3, 3);
        exp_rd = exp_q.pop_front();
        checks++;
        if (obs_stall != exp_stall) begin errors++; $display("FAIL store_stall: got %0d want %0d", obs_stall, exp_stall); end
        checks++;
        if (obs_we !== 1'b1 || obs_wdata !== 32'h1234_5678 || obs_unstable !== 1'b0 || obs_req != exp_req) begin
            errors++; $display("FAIL store_bus: got we=%b wdata=%h unstable=%b req=%0d want 1/12345678/0/%0d",
                               obs_we, obs_wdata, obs_unstable, obs_req, exp_req);
        end
        checks++;
        if (obs_rd !== exp_rd) begin errors++; $display("FAIL store_rdata_kept: got %h want %h", obs_rd, exp_rd); end
    endtask

    task automatic test_faults;
        logic [AW-1:0] addrs [3];
        logic [1:0]    ops   [3];
        addrs[0] = 32'h13; ops[0] = 2'b10;
        addrs[1] = 32'h40; ops[1] = 2'b11;
        addrs[2] = 32'h13; ops[2] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            predict(ops[i][1], ops[i][0], addrs[i], 32'h5555_AAAA, 1);
            run_access(ops[i][1], ops[i][0], addrs[i], 32'h0, 32'h5555_AAAA, 1, 3);
            exp_rd = exp_q.pop_front();
            checks++;
            if (obs_err != exp_err || obs_req != 0 || obs_stall != 0 || obs_rd !== exp_rd) begin
                errors++;
                $display("FAIL fault_%0d: got err=%0d req=%0d stall=%0d rd=%h want %0d/0/0/%h",
                         i, obs_err, obs_req, obs_stall, obs_rd, exp_err, exp_rd);
            end
        end
    endtask

    task automatic test_timeout;
        predict(1'b1, 1'b0, 32'h30, 32'h0BAD_0BAD, 0);
        run_access(1'b1, 1'b0, 32'h30, 32'h0, 32'h0BAD_0BAD, 0, 3);
        exp_rd = exp_q.pop_front();
        checks++;
        if (obs_req != exp_req || obs_stall != exp_stall) begin
            errors++; $display("FAIL timeout_len: got req=%0d stall=%0d want %0d/%0d", obs_req, obs_stall, exp_req, exp_stall);
        end
        checks++;
        if (obs_err != exp_err) begin errors++; $display("FAIL timeout_err: got %0d pulses want %0d", obs_err, exp_err); end
        checks++;
        if (obs_rd !== exp_rd) begin errors++; $display("FAIL timeout_rdata: got %h want %h", obs_rd, exp_rd); end
    endtask

    task automatic test_reset_mid_access;
        mem_read = 1'b1; alu_result = 32'h44;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk); @(posedge clk); #1;
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, stall, bus_error} !== 3'b000 || read_data !== '0) begin
            errors++; $display("FAIL reset_mid: got req/stall/err=%b rd=%h want 000/0", {mem_req, stall, bus_error}, read_data);
        end
        model_rd = '0;
        @(posedge clk); #1;
        mem_read = 1'b0; alu_result = '0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        predict(1'b1, 1'b0, 32'h48, 32'hCAFE_F00D, 2);
        run_access(1'b1, 1'b0, 32'h48, 32'h0, 32'hCAFE_F00D, 2, 3);
        exp_rd = exp_q.pop_front();
        checks++;
        if (obs_rd !== exp_rd || obs_stall != exp_stall || obs_err != exp_err) begin
            errors++; $display("FAIL reset_recover: got rd=%h stall=%0d err=%0d want %h/%0d/%0d",
                               obs_rd, obs_stall, obs_err, exp_rd, exp_stall, exp_err);
        end
    endtask

    task automatic test_back_to_back;
        mem_ack = 1'b1; mem_rdata = 32'hBADB_AD00;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL stray_ack_idle: got req=%b stall=%b want 0/0", mem_req, stall);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (read_data !== model_rd || bus_error !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL stray_ack_after: got rd=%h err=%b req=%b want %h/0/0", read_data, bus_error, mem_req, model_rd);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            a = (i == 0) ? 32'h4 : 32'h8;
            d = 32'hA000_0000 + a;
            predict(1'b1, 1'b0, a, d, 1);
            run_access(1'b1, 1'b0, a, 32'h0, d, 1, (i == 0) ? 0 : 3);
            exp_rd = exp_q.pop_front();
            checks++;
            if (obs_rd !== exp_rd || obs_stall != exp_stall || obs_req != exp_req || obs_addr !== a) begin
                errors++; $display("FAIL b2b_%0d: got rd=%h stall=%0d req=%0d addr=%h want %h/%0d/%0d/%h",
                                   i, obs_rd, obs_stall, obs_req, obs_addr, exp_rd, exp_stall, exp_req, a);
            end
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            int            sel, lat;
            logic          rd, wr;
            logic [AW-1:0] addr;
            logic [DW-1:0] wd, rdat;
            sel  = $urandom_range(0, 9);
            rd   = (sel <= 3) || (sel == 8);
            wr   = (sel >= 4 && sel <= 8);
            addr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            wd   = $urandom;
            rdat = $urandom;
            lat  = $urandom_range(0, TO + 2);
            predict(rd, wr, addr, rdat, lat);
            run_access(rd, wr, addr, wd, rdat, lat, 1);
            exp_rd = exp_q.pop_front();
            checks++;
            if (obs_stall != exp_stall || obs_req != exp_req || obs_err != exp_err || obs_rd !== exp_rd) begin
                errors++; $display("FAIL rand_%0d: got stall=%0d req=%0d err=%0d rd=%h want %0d/%0d/%0d/%h",
                                   n, obs_stall, obs_req, obs_err, obs_rd, exp_stall, exp_req, exp_err, exp_rd);
            end
            if (exp_valid) begin
                checks++;
                if (obs_addr !== addr || obs_we !== wr || obs_unstable !== 1'b0 || (wr && obs_wdata !== wd)) begin
                    errors++; $display("FAIL rand_bus_%0d: got addr=%h we=%b wdata=%h unstable=%b want %h/%b/%h/0",
                                       n, obs_addr, obs_we, obs_wdata, obs_unstable, addr, wr, wd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_zero_wait();
        test_store_wait();
        test_faults();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
